// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared types and constants for the sequential restoring divider.
//   Widths, iteration count, FSM state encoding and the fixed result
//   returned for a zero divisor.
package seq_divider_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int ITER       = 16;
   localparam int CNT_W      = 4;

   localparam logic [DIVIDEND_W-1:0] QUOT_DZ = 16'hFFFF;
   localparam logic [DIVISOR_W-1:0]  REM_DZ  = 8'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Operand/result handshake bundle for seq_divider.
//   master : producer of operands and consumer of results (upstream/testbench)
//   slave  : the divider itself
//   Signals: in_valid/in_ready/dividend/divisor[/signed_op] on the input side,
//            out_valid/out_ready/quotient/remainder/dz on the output side.
//   signed_op exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if;
   import seq_divider_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic                  signed_op;
`endif
   logic                  out_valid;
   logic                  out_ready;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  dz;

   modport master (
`ifdef SEQ_DIVIDER_SIGNED_EN
      output signed_op,
`endif
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, dz
   );

   modport slave (
`ifdef SEQ_DIVIDER_SIGNED_EN
      input  signed_op,
`endif
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, dz
   );

endinterface

// File: rtl/seq_divider_div_step.sv
// div_step
//   One combinational restoring-division step.
//   Ports: r_in  - current partial remainder (always < divisor)
//          q_msb - next dividend bit shifted into the remainder
//          d     - divisor
//          r_out - partial remainder after the step
//          q_bit - quotient bit produced by the step
module div_step
   import seq_divider_pkg::*;
(
   input  logic [DIVISOR_W-1:0] r_in,
   input  logic                 q_msb,
   input  logic [DIVISOR_W-1:0] d,
   output logic [DIVISOR_W-1:0] r_out,
   output logic                 q_bit
);

   // Trial value needs one extra bit; the result always fits back in
   // DIVISOR_W bits because T < 2*D whenever the subtraction is taken.
   logic [DIVISOR_W:0] t;

   always_comb begin
      t     = {r_in, q_msb};
      r_out = t[DIVISOR_W-1:0];
      q_bit = 1'b0;
      if (t >= {1'b0, d}) begin
         r_out = DIVISOR_W'(t - {1'b0, d});
         q_bit = 1'b1;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Iterative restoring divider: DIVIDEND_W / DIVISOR_W -> quotient, remainder.
//   One quotient bit per clock, no overlap between operations.
//   Ports: clk  - rising-edge clock
//          rst  - synchronous active-high reset
//          bus  - seq_divider_if.slave (operand and result handshakes)
//   Build option: SEQ_DIVIDER_SIGNED_EN adds signed_op and the FIX state
//   for two's-complement operation.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   CALC  | one restoring step per cycle, ITER cycles
//   FIX   | apply result signs (signed build, signed_op=1 only)
//   DONE  | out_valid=1, result held until out_ready
module seq_divider (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   import seq_divider_pkg::*;

   state_e                state_q, state_d;
   logic [DIVISOR_W-1:0]  r_q, r_d;
   logic [DIVIDEND_W-1:0] q_q, q_d;
   logic [DIVISOR_W-1:0]  d_q, d_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  dz_q, dz_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

   logic [DIVIDEND_W-1:0] dvd_mag;
   logic [DIVISOR_W-1:0]  dvs_mag;
   logic [DIVISOR_W-1:0]  r_next;
   logic                  q_bit;
   logic [DIVIDEND_W-1:0] q_next;
   logic                  last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic sgn_q, sgn_d;
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;
   logic dvd_neg, dvs_neg;

   assign dvd_neg = bus.signed_op & bus.dividend[DIVIDEND_W-1];
   assign dvs_neg = bus.signed_op & bus.divisor[DIVISOR_W-1];
   // -32768 and -128 have magnitudes that still fit as unsigned values.
   assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
   assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
`else
   assign dvd_mag = bus.dividend;
   assign dvs_mag = bus.divisor;
`endif

   div_step u_div_step (
      .r_in  (r_q),
      .q_msb (q_q[DIVIDEND_W-1]),
      .d     (d_q),
      .r_out (r_next),
      .q_bit (q_bit)
   );

   assign q_next    = {q_q[DIVIDEND_W-2:0], q_bit};
   assign last_step = (cnt_q == CNT_W'(ITER - 1));

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sgn_d       = sgn_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = CALC;
               r_d     = '0;
               q_d     = dvd_mag;
               d_d     = dvs_mag;
               cnt_d   = '0;
               dz_d    = (bus.divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
               sgn_d     = bus.signed_op;
               neg_quo_d = dvd_neg ^ dvs_neg;
               neg_rem_d = dvd_neg;
`endif
            end
         end

         CALC: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d     = DONE;
               quotient_d  = dz_q ? QUOT_DZ : q_next;
               remainder_d = dz_q ? REM_DZ  : r_next;
`ifdef SEQ_DIVIDER_SIGNED_EN
               if (sgn_q) begin
                  state_d     = FIX;
                  quotient_d  = quotient_q;
                  remainder_d = remainder_q;
               end
`endif
            end
         end

         FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            state_d     = DONE;
            quotient_d  = dz_q ? QUOT_DZ : (neg_quo_q ? -q_q : q_q);
            remainder_d = dz_q ? REM_DZ  : (neg_rem_q ? -r_q : r_q);
`else
            state_d = IDLE;
`endif
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         sgn_q       <= 1'b0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
         sgn_q       <= sgn_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.dz        = dz_q;

endmodule
